// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// memory latency bound and reset values for the PC and instruction registers.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CAPTURE,
        HALTED
    } state_t;

    localparam int MEM_LAT_MAX     = 4;
    localparam int WAIT_CNT_W      = $clog2(MEM_LAT_MAX);
    localparam int PC_RESET_VAL    = 0;
    localparam int INSTR_RESET_VAL = 0;

    // WAIT runs MEM_LAT-1 cycles, so the down-counter starts at MEM_LAT-2.
    function automatic logic [WAIT_CNT_W-1:0] waitLoad(input int memLat);
        return (memLat > 1) ? WAIT_CNT_W'(memLat - 2) : '0;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Controller/memory/IR side bundle of the fetch unit. The master side is whoever
// drives the controller handshake and returns memory data; the slave is the fetch unit.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               fetch_req;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt;
    logic               imem_rd;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               halted;

    modport master (
        output fetch_req, jump_en, jump_addr, halt, imem_data,
        input  imem_rd, imem_addr, instr, instr_valid, pc, busy, halted
    );

    modport slave (
        input  fetch_req, jump_en, jump_addr, halt, imem_data,
        output imem_rd, imem_addr, instr, instr_valid, pc, busy, halted
    );

endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: loads a new value (jump target or post-fetch increment)
// when told to, otherwise holds.
module pc_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_loadVal,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= ADDR_W'(PC_RESET_VAL);
        end else if (i_load) begin
            r_pc <= i_loadVal;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues reads to a synchronous instruction memory and
// delivers each returned word to the instruction register with a one-cycle valid strobe.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          RST,
    instr_fetch_if.slave  io_fetch
);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_waitCnt;
    logic                  r_haltPend;
    logic                  r_imemRd;
    logic [ADDR_W-1:0]     r_imemAddr;
    logic [INSTR_W-1:0]    r_instr;
    logic                  r_instrValid;

    logic                  w_pcLoad;
    logic [ADDR_W-1:0]     w_pcLoadVal;
    logic [ADDR_W-1:0]     w_pc;

    // PC moves on a jump in IDLE (with or without a fetch) and after every capture.
    always_comb begin
        w_pcLoad    = 1'b0;
        w_pcLoadVal = r_imemAddr + 1'b1;
        case (r_state)
            IDLE: begin
                if (!io_fetch.halt && io_fetch.jump_en) begin
                    w_pcLoad    = 1'b1;
                    w_pcLoadVal = io_fetch.jump_addr;
                end
            end
            CAPTURE: begin
                w_pcLoad = 1'b1;
            end
            default: begin
                w_pcLoad = 1'b0;
            end
        endcase
    end

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pcCounter (
        .clk       (clk),
        .rst       (RST),
        .i_load    (w_pcLoad),
        .i_loadVal (w_pcLoadVal),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_waitCnt    <= '0;
            r_haltPend   <= 1'b0;
            r_imemRd     <= 1'b0;
            r_imemAddr   <= ADDR_W'(PC_RESET_VAL);
            r_instr      <= INSTR_W'(INSTR_RESET_VAL);
            r_instrValid <= 1'b0;
        end else begin
            r_imemRd     <= 1'b0;
            r_instrValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_fetch.halt) begin
                        r_state <= HALTED;
                    end else if (io_fetch.fetch_req) begin
                        r_state    <= READ;
                        r_imemRd   <= 1'b1;
                        r_imemAddr <= io_fetch.jump_en ? io_fetch.jump_addr : w_pc;
                    end
                end
                READ: begin
                    r_haltPend <= r_haltPend | io_fetch.halt;
                    if (MEM_LAT > 1) begin
                        r_state   <= WAIT;
                        r_waitCnt <= waitLoad(MEM_LAT);
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                WAIT: begin
                    r_haltPend <= r_haltPend | io_fetch.halt;
                    if (r_waitCnt == '0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_waitCnt <= r_waitCnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    r_instr      <= io_fetch.imem_data;
                    r_instrValid <= 1'b1;
                    r_haltPend   <= r_haltPend | io_fetch.halt;
                    r_state      <= (r_haltPend || io_fetch.halt) ? HALTED : IDLE;
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_fetch.imem_rd     = r_imemRd;
    assign io_fetch.imem_addr   = r_imemAddr;
    assign io_fetch.instr       = r_instr;
    assign io_fetch.instr_valid = r_instrValid;
    assign io_fetch.pc          = w_pc;
    assign io_fetch.busy        = (r_state != IDLE) && (r_state != HALTED);
    assign io_fetch.halted      = (r_state == HALTED);

endmodule
